prediction_mac_seq: RTL and testbench

Sequential, parametrised successor to the combinational neuron-prediction dot product. It accepts a packed weight row and a packed neuron state vector through a valid/ready handshake. It accumulates `LANES` signed products per cycle into a full-width accumulator, then returns a saturated result through a valid/ready handshake. It sits between the weight/state fetch logic and the neuron update stage of the network core.

---
 rtl/prediction_pkg.sv | 18 +
 rtl/prediction_lane_sum.sv | 43 ++++
 rtl/prediction_mac_seq.sv | 163 ++++++++++++++++
 tb/tb_prediction_mac_seq.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prediction_pkg.sv
// Shared types, constants and helpers for the sequential neuron-prediction MAC.
package prediction_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Hopfield neuron states for the default two-bit state width
  localparam logic signed [1:0] STATE_POS = 2'sb01;
  localparam logic signed [1:0] STATE_NEG = 2'sb11;

  function automatic int acc_width(input int n, input int w_weight, input int w_state);
    return w_weight + w_state + $clog2(n);
  endfunction

endpackage

// File: rtl/prediction_lane_sum.sv
// Combinational sum of one chunk of LANES signed weight*state products;
// lanes that fall past the last neuron contribute zero.
module prediction_lane_sum
  import prediction_pkg::*;
#(
  parameter int N_NEURONS = 20,
  parameter int W_WEIGHT  = 10,
  parameter int W_STATE   = 2,
  parameter int LANES     = 4,
  parameter int W_ACC     = acc_width(N_NEURONS, W_WEIGHT, W_STATE),
  parameter int W_K       = 3
) (
  input  logic [N_NEURONS*W_WEIGHT-1:0] weights_i,
  input  logic [N_NEURONS*W_STATE-1:0]  states_i,
  input  logic [W_K-1:0]                k_i,
  output logic signed [W_ACC-1:0]       sum_o
);

  localparam int W_PROD = W_WEIGHT + W_STATE;

  always_comb begin
    int                          idx;
    logic signed [W_WEIGHT-1:0]  w;
    logic signed [W_STATE-1:0]   s;
    logic signed [W_PROD-1:0]    prod;
    // NOTE: every variable gets a value before any branch so no latch can be inferred.
    sum_o = '0;
    idx   = 0;
    w     = '0;
    s     = '0;
    prod  = '0;
    for (int l = 0; l < LANES; l++) begin
      idx = int'(k_i) * LANES + l;
      if (idx < N_NEURONS) begin
        w     = weights_i[W_WEIGHT*idx +: W_WEIGHT];
        s     = states_i[W_STATE*idx +: W_STATE];
        prod  = W_PROD'(w) * W_PROD'(s);
        sum_o = sum_o + W_ACC'(prod);
      end
    end
  end

endmodule

// File: rtl/prediction_mac_seq.sv
// Sequential LANES-wide signed dot product with valid/ready handshakes and
// saturated output. Optional sign activation output: PREDICTION_SIGN_OUT_EN.
module prediction_mac_seq
  import prediction_pkg::*;
#(
  parameter int N_NEURONS = 20,
  parameter int W_WEIGHT  = 10,
  parameter int W_STATE   = 2,
  parameter int LANES     = 4,
  parameter int W_OUT     = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_NEURONS*W_WEIGHT-1:0] weights_packed,
  input  logic [N_NEURONS*W_STATE-1:0]  states_packed,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [W_OUT-1:0]              y,
  output logic                          sat
`ifdef PREDICTION_SIGN_OUT_EN
  ,
  output logic [W_STATE-1:0]            x_new
`endif
);

  localparam int W_ACC  = acc_width(N_NEURONS, W_WEIGHT, W_STATE);
  localparam int CHUNKS = (N_NEURONS + LANES - 1) / LANES;
  localparam int W_K    = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [W_K-1:0] K_LAST = W_K'(CHUNKS - 1);
  // Clamp compare width covers both the accumulator and the output range
  localparam int W_CMP  = ((W_ACC > W_OUT) ? W_ACC : W_OUT) + 1;
  localparam logic signed [W_CMP-1:0] Y_MAX = W_CMP'((64'sd1 <<< (W_OUT - 1)) - 64'sd1);
  localparam logic signed [W_CMP-1:0] Y_MIN = ~Y_MAX;

  state_e                        state_q, state_d;
  logic signed [W_ACC-1:0]       acc_q, acc_d;
  logic [W_K-1:0]                k_q, k_d;
  logic                          out_valid_q;
  logic [W_OUT-1:0]              y_q;
  logic                          sat_q;
  logic [N_NEURONS*W_WEIGHT-1:0] w_q;
  logic [N_NEURONS*W_STATE-1:0]  s_q;
  logic                          load;
  logic                          result_load;
  logic signed [W_ACC-1:0]       lane_sum;
  logic signed [W_ACC-1:0]       sum_final;
  logic signed [W_CMP-1:0]       sum_ext;
  logic [W_OUT-1:0]              y_sat;
  logic                          sat_hit;

  prediction_lane_sum #(
    .N_NEURONS (N_NEURONS),
    .W_WEIGHT  (W_WEIGHT),
    .W_STATE   (W_STATE),
    .LANES     (LANES),
    .W_ACC     (W_ACC),
    .W_K       (W_K)
  ) u_lane_sum (
    .weights_i (w_q),
    .states_i  (s_q),
    .k_i       (k_q),
    .sum_o     (lane_sum)
  );

  assign sum_final = acc_q + lane_sum;
  assign sum_ext   = W_CMP'(sum_final);

  always_comb begin
    sat_hit = 1'b0;
    y_sat   = sum_ext[W_OUT-1:0];
    if (sum_ext > Y_MAX) begin
      sat_hit = 1'b1;
      y_sat   = Y_MAX[W_OUT-1:0];
    end else if (sum_ext < Y_MIN) begin
      sat_hit = 1'b1;
      y_sat   = Y_MIN[W_OUT-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    k_d         = k_q;
    load        = 1'b0;
    result_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          acc_d   = '0;
          k_d     = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d = sum_final;
        k_d   = k_q + W_K'(1);
        if (k_q == K_LAST) begin
          result_load = 1'b1;
          k_d         = '0;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      out_valid_q <= (state_d == DONE);
      if (result_load) begin
        y_q   <= y_sat;
        sat_q <= sat_hit;
      end
    end
  end

  // NOTE: operand registers are wide datapath storage written on accept before any read, so no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      w_q <= weights_packed;
      s_q <= states_packed;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign sat       = sat_q;

`ifdef PREDICTION_SIGN_OUT_EN
  logic [W_STATE-1:0] x_new_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_new_q <= W_STATE'(STATE_POS);
    end else if (result_load) begin
      x_new_q <= y_sat[W_OUT-1] ? W_STATE'(STATE_NEG) : W_STATE'(STATE_POS);
    end
  end

  assign x_new = x_new_q;
`else
  // Sign activation output is not built in this configuration.
`endif

endmodule

// File: tb/tb_prediction_mac_seq.sv
// Self-checking bench for prediction_mac_seq: directed, random, backpressure,
// back-to-back, mid-operation reset and padded-lane scenarios.
module tb_prediction_mac_seq;

  localparam int N   = 20;
  localparam int WW  = 10;
  localparam int WS  = 2;
  localparam int L   = 4;
  localparam int WO  = 10;
  localparam int CH  = 5;
  localparam int N6  = 6;
  localparam int CH6 = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, out_ready;
  logic [N*WW-1:0] weights;
  logic [N*WS-1:0] states;
  logic          in_ready, out_valid;
  logic [WO-1:0] y;
  logic          sat;

  logic           in_valid6, out_ready6;
  logic [N6*WW-1:0] weights6;
  logic [N6*WS-1:0] states6;
  logic           in_ready6, out_valid6;
  logic [WO-1:0]  y6;
  logic           sat6;

`ifdef PREDICTION_SIGN_OUT_EN
  logic [WS-1:0] x_new, x_new6;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc;

  prediction_mac_seq #(
    .N_NEURONS(N), .W_WEIGHT(WW), .W_STATE(WS), .LANES(L), .W_OUT(WO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .weights_packed(weights), .states_packed(states),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .sat(sat)
`ifdef PREDICTION_SIGN_OUT_EN
    , .x_new(x_new)
`endif
  );

  prediction_mac_seq #(
    .N_NEURONS(N6), .W_WEIGHT(WW), .W_STATE(WS), .LANES(L), .W_OUT(WO)
  ) dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid6), .in_ready(in_ready6),
    .weights_packed(weights6), .states_packed(states6),
    .out_valid(out_valid6), .out_ready(out_ready6), .y(y6), .sat(sat6)
`ifdef PREDICTION_SIGN_OUT_EN
    , .x_new(x_new6)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer dot product followed by clamping to the output range
  function automatic void model(input logic [N*WW-1:0] wp, input logic [N*WS-1:0] sp,
                                input int n, output int ey, output bit esat);
    int acc;
    acc = 0;
    for (int j = 0; j < n; j++)
      acc += int'($signed(wp[j*WW +: WW])) * int'($signed(sp[j*WS +: WS]));
    esat = 1'b0;
    ey   = acc;
    if (acc > 511) begin
      ey = 511; esat = 1'b1;
    end else if (acc < -512) begin
      ey = -512; esat = 1'b1;
    end
  endfunction

  task automatic rand_ops(output logic [N*WW-1:0] wp, output logic [N*WS-1:0] sp);
    for (int j = 0; j < N; j++) begin
      wp[j*WW +: WW] = WW'($urandom);
      sp[j*WS +: WS] = WS'($urandom);
    end
  endtask

  // Present one operand set for a single cycle, then scramble the inputs
  task automatic send(input logic [N*WW-1:0] wp, input logic [N*WS-1:0] sp);
    logic [N*WW-1:0] jw;
    logic [N*WS-1:0] js;
    in_valid = 1'b1;
    weights  = wp;
    states   = sp;
    @(negedge clk);
    acc_cyc  = cyc;
    in_valid = 1'b0;
    rand_ops(jw, js);
    weights  = jw;
    states   = js;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; weights = '0; states = '0;
    in_valid6 = 1'b0; out_ready6 = 1'b0; weights6 = '0; states6 = '0;
    repeat (3) @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    total++; if (y !== '0) begin bad++; $display("FAIL reset_y: got %0d expected 0", $signed(y)); end
    total++; if (sat !== 1'b0) begin bad++; $display("FAIL reset_sat: got %b expected 0", sat); end
`ifdef PREDICTION_SIGN_OUT_EN
    total++; if (x_new !== 2'b01) begin bad++; $display("FAIL reset_x_new: got %b expected 01", x_new); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    int exp_y [4] = '{20, -10, 511, -512};
    bit exp_s [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [N*WW-1:0] wp;
    logic [N*WS-1:0] sp;
    int lat, yv;
    for (int t = 0; t < 4; t++) begin
      for (int j = 0; j < N; j++) begin
        case (t)
          0: begin wp[j*WW +: WW] = WW'(1);      sp[j*WS +: WS] = 2'b01; end
          1: begin wp[j*WW +: WW] = WW'(j - 10); sp[j*WS +: WS] = (j % 2 == 0) ? 2'b01 : 2'b11; end
          2: begin wp[j*WW +: WW] = WW'(511);    sp[j*WS +: WS] = 2'b01; end
          default: begin wp[j*WW +: WW] = WW'(-512); sp[j*WS +: WS] = 2'b01; end
        endcase
      end
      send(wp, sp);
      wait_out(lat);
      yv = int'($signed(y));
      total++; if (lat !== CH) begin bad++; $display("FAIL dir%0d_latency: got %0d expected %0d", t, lat, CH); end
      total++; if (yv !== exp_y[t]) begin bad++; $display("FAIL dir%0d_y: got %0d expected %0d", t, yv, exp_y[t]); end
      total++; if (sat !== exp_s[t]) begin bad++; $display("FAIL dir%0d_sat: got %b expected %b", t, sat, exp_s[t]); end
`ifdef PREDICTION_SIGN_OUT_EN
      total++;
      if (x_new !== ((exp_y[t] >= 0) ? 2'b01 : 2'b11)) begin
        bad++; $display("FAIL dir%0d_x_new: got %b for y %0d", t, x_new, exp_y[t]);
      end
`endif
      release_out();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL dir%0d_in_ready: got %b expected 1", t, in_ready); end
    end
  endtask

  task automatic test_random();
    logic [N*WW-1:0] wp;
    logic [N*WS-1:0] sp;
    int lat, yv, ey;
    bit es;
    for (int t = 0; t < 20; t++) begin
      rand_ops(wp, sp);
      model(wp, sp, N, ey, es);
      send(wp, sp);
      wait_out(lat);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      yv = int'($signed(y));
      total++; if (lat !== CH) begin bad++; $display("FAIL rnd%0d_latency: got %0d expected %0d", t, lat, CH); end
      total++; if (yv !== ey) begin bad++; $display("FAIL rnd%0d_y: got %0d expected %0d", t, yv, ey); end
      total++; if (sat !== es) begin bad++; $display("FAIL rnd%0d_sat: got %b expected %b", t, sat, es); end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    logic [N*WW-1:0] wp, jw;
    logic [N*WS-1:0] sp, js;
    int lat, yv, ey;
    bit es;
    rand_ops(wp, sp);
    model(wp, sp, N, ey, es);
    send(wp, sp);
    wait_out(lat);
    for (int c = 0; c < 10; c++) begin
      rand_ops(jw, js);
      in_valid = c[0];
      weights  = jw;
      states   = js;
      @(negedge clk);
      yv = int'($signed(y));
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp%0d_out_valid: got %b expected 1", c, out_valid); end
      total++; if (yv !== ey) begin bad++; $display("FAIL bp%0d_y_stable: got %0d expected %0d", c, yv, ey); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp%0d_in_ready: got %b expected 0", c, in_ready); end
    end
    in_valid = 1'b0;
    release_out();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready: got %b expected 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_out_valid: got %b expected 0", out_valid); end
    repeat (CH + 2) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_ignored_in_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [N*WW-1:0] wp;
    logic [N*WS-1:0] sp;
    int lat, yv, ey, prev;
    bit es;
    out_ready = 1'b1;
    prev = -1;
    for (int t = 0; t < 4; t++) begin
      rand_ops(wp, sp);
      model(wp, sp, N, ey, es);
      send(wp, sp);
      if (prev >= 0) begin
        total++;
        if (acc_cyc - prev !== CH + 2) begin
          bad++; $display("FAIL b2b%0d_period: got %0d expected %0d", t, acc_cyc - prev, CH + 2);
        end
      end
      prev = acc_cyc;
      wait_out(lat);
      yv = int'($signed(y));
      total++; if (lat !== CH) begin bad++; $display("FAIL b2b%0d_latency: got %0d expected %0d", t, lat, CH); end
      total++; if (yv !== ey) begin bad++; $display("FAIL b2b%0d_y: got %0d expected %0d", t, yv, ey); end
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b%0d_one_done_cycle: got %b expected 0", t, out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b%0d_in_ready: got %b expected 1", t, in_ready); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_acc();
    logic [N*WW-1:0] wp;
    logic [N*WS-1:0] sp;
    int lat, yv, ey;
    bit es;
    for (int j = 0; j < N; j++) begin wp[j*WW +: WW] = WW'(1); sp[j*WS +: WS] = 2'b01; end
    send(wp, sp);
    wait_out(lat);
    release_out();
    rand_ops(wp, sp);
    send(wp, sp);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
    total++; if (y !== '0) begin bad++; $display("FAIL midrst_y: got %0d expected 0", $signed(y)); end
    total++; if (sat !== 1'b0) begin bad++; $display("FAIL midrst_sat: got %b expected 0", sat); end
    repeat (CH + 2) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_abandoned: got %b expected 0", out_valid); end
    rand_ops(wp, sp);
    model(wp, sp, N, ey, es);
    send(wp, sp);
    wait_out(lat);
    yv = int'($signed(y));
    total++; if (lat !== CH) begin bad++; $display("FAIL midrst_new_latency: got %0d expected %0d", lat, CH); end
    total++; if (yv !== ey) begin bad++; $display("FAIL midrst_new_y: got %0d expected %0d", yv, ey); end
    total++; if (sat !== es) begin bad++; $display("FAIL midrst_new_sat: got %b expected %b", sat, es); end
    release_out();
  endtask

  task automatic test_padding();
    int lat, yv;
    for (int j = 0; j < N6; j++) begin
      weights6[j*WW +: WW] = WW'(j + 1);
      states6[j*WS +: WS]  = 2'b10;
    end
    in_valid6 = 1'b1;
    @(negedge clk);
    in_valid6 = 1'b0;
    weights6  = '1;
    states6   = '1;
    lat = 0;
    while (!out_valid6 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    yv = int'($signed(y6));
    total++; if (lat !== CH6) begin bad++; $display("FAIL pad_latency: got %0d expected %0d", lat, CH6); end
    total++; if (yv !== -42) begin bad++; $display("FAIL pad_y: got %0d expected -42", yv); end
    total++; if (sat6 !== 1'b0) begin bad++; $display("FAIL pad_sat: got %b expected 0", sat6); end
    out_ready6 = 1'b1;
    @(negedge clk);
    out_ready6 = 1'b0;
    total++; if (in_ready6 !== 1'b1) begin bad++; $display("FAIL pad_in_ready: got %b expected 1", in_ready6); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_acc();
    test_padding();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
